// File: rtl/writeback_unit.sv
// Writeback stage: buffers MEM results, serialises vector results into four
// component writes, and drives RF/VRF/CC/PC strobes. Option: WB_RETIRE_CNT_EN.
module writeback_unit #(
  parameter int REG_WIDTH     = 16,
  parameter int VREG_WIDTH    = 64,
  parameter int VREG_ID_WIDTH = 6,
  parameter int PC_WIDTH      = 16,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_MW_Valid,
  output logic                     O_MW_Ready,
  input  logic                     I_MW_RegWrite,
  input  logic                     I_MW_VRegWrite,
  input  logic                     I_MW_CCWrite,
  input  logic [3:0]               I_MW_DestRegIdx,
  input  logic [VREG_ID_WIDTH-1:0] I_MW_DestVRegIdx,
  input  logic [REG_WIDTH-1:0]     I_MW_Data,
  input  logic [VREG_WIDTH-1:0]    I_MW_VecData,
  input  logic                     I_MW_PCWrite,
  input  logic [PC_WIDTH-1:0]      I_MW_TargetPC,
  output logic                     O_RegWEn,
  output logic [3:0]               O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]     O_WriteBackData,
  output logic                     O_CCWEn,
  output logic [2:0]               O_CCValue,
  output logic                     O_VRegWEn,
  output logic [VREG_ID_WIDTH-1:0] O_WriteBackVRegIdx,
  output logic [1:0]               O_VecCompIdx,
  output logic [PC_WIDTH-1:0]      O_WriteBackPC,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]              O_RetireCount,
`endif
  output logic                     O_WriteBackPCEn,
  output logic                     O_Busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic                     regw;
    logic                     vregw;
    logic                     ccw;
    logic                     pcw;
    logic [3:0]               idx;
    logic [VREG_ID_WIDTH-1:0] vidx;
    logic [REG_WIDTH-1:0]     data;
    logic [VREG_WIDTH-1:0]    vec;
    logic [PC_WIDTH-1:0]      pc;
  } ent_t;

  typedef enum logic {S_IDLE, S_VEC} state_t;

  ent_t                     r_mem [FIFO_DEPTH];
  logic [PW-1:0]            r_wp;
  logic [PW-1:0]            r_rp;
  logic [CW-1:0]            r_count;
  logic                     r_ready;
  logic                     r_busy;
  state_t                   r_state;
  logic [1:0]               r_cnt;
  logic [VREG_WIDTH-1:0]    r_vec;
  logic [VREG_ID_WIDTH-1:0] r_vidx;

  logic                     r_regwen;
  logic [3:0]               r_wbidx;
  logic [REG_WIDTH-1:0]     r_wbdata;
  logic                     r_ccwen;
  logic [2:0]               r_cc;
  logic                     r_vregwen;
  logic [VREG_ID_WIDTH-1:0] r_wbvidx;
  logic [1:0]               r_vcomp;
  logic [PC_WIDTH-1:0]      r_pc;
  logic                     r_pcen;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]              r_retire;
`endif

  ent_t                     w_head;
  ent_t                     w_in;
  logic                     w_take;
  logic                     w_push;
  logic [CW-1:0]            w_count_nxt;
  state_t                   w_state_nxt;
  logic [REG_WIDTH-1:0]     w_comp;
  logic [2:0]               w_cc;

  // Head decode, handshake and next-state selection
  always_comb begin
    w_in.regw   = I_MW_RegWrite;
    w_in.vregw  = I_MW_VRegWrite;
    w_in.ccw    = I_MW_CCWrite;
    w_in.pcw    = I_MW_PCWrite;
    w_in.idx    = I_MW_DestRegIdx;
    w_in.vidx   = I_MW_DestVRegIdx;
    w_in.data   = I_MW_Data;
    w_in.vec    = I_MW_VecData;
    w_in.pc     = I_MW_TargetPC;
    w_head      = r_mem[r_rp];
    w_push      = I_MW_Valid && r_ready;
    // the head may be taken when idle or while component 3 is on the output
    w_take      = (r_count != '0) &&
                  ((r_state == S_IDLE) || (r_cnt == 2'd0));
    w_count_nxt = r_count + CW'(w_push) - CW'(w_take);
    w_comp      = r_vec[int'(r_cnt)*REG_WIDTH +: REG_WIDTH];
    if (w_head.data[REG_WIDTH-1])
      w_cc = 3'b100;
    else if (w_head.data == '0)
      w_cc = 3'b010;
    else
      w_cc = 3'b001;
    w_state_nxt = S_IDLE;
    if ((r_state == S_VEC) && (r_cnt != 2'd0))
      w_state_nxt = S_VEC;
    else if (w_take && w_head.vregw)
      w_state_nxt = S_VEC;
  end

  // Result buffer storage
  always_ff @(posedge I_CLOCK) begin
    if (w_push)
      r_mem[r_wp] <= w_in;
  end

  // Pointers, FSM and registered beat outputs
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_vec     <= '0;
      r_vidx    <= '0;
      r_regwen  <= 1'b0;
      r_wbidx   <= '0;
      r_wbdata  <= '0;
      r_ccwen   <= 1'b0;
      r_cc      <= 3'b000;
      r_vregwen <= 1'b0;
      r_wbvidx  <= '0;
      r_vcomp   <= 2'd0;
      r_pc      <= '0;
      r_pcen    <= 1'b0;
`ifdef WB_RETIRE_CNT_EN
      r_retire  <= '0;
`endif
    end else begin
      r_count   <= w_count_nxt;
      r_ready   <= w_count_nxt < DEPTH_C;
      r_busy    <= (w_count_nxt != '0) || (w_state_nxt == S_VEC);
      r_state   <= w_state_nxt;
      if (w_push)
        r_wp <= r_wp + PW'(1);
      if (w_take)
        r_rp <= r_rp + PW'(1);
      r_regwen  <= 1'b0;
      r_wbidx   <= '0;
      r_wbdata  <= '0;
      r_ccwen   <= 1'b0;
      r_cc      <= 3'b000;
      r_vregwen <= 1'b0;
      r_wbvidx  <= '0;
      r_vcomp   <= 2'd0;
      r_pc      <= '0;
      r_pcen    <= 1'b0;
      if ((r_state == S_VEC) && (r_cnt != 2'd0)) begin
        r_vregwen <= 1'b1;
        r_wbvidx  <= r_vidx;
        r_vcomp   <= r_cnt;
        r_wbdata  <= w_comp;
        r_cnt     <= r_cnt + 2'd1;
`ifdef WB_RETIRE_CNT_EN
        if (r_cnt == 2'd3)
          r_retire <= r_retire + 32'd1;
`endif
      end else if (w_take && w_head.vregw) begin
        r_vregwen <= 1'b1;
        r_wbvidx  <= w_head.vidx;
        r_vcomp   <= 2'd0;
        r_wbdata  <= w_head.vec[0 +: REG_WIDTH];
        r_vec     <= w_head.vec;
        r_vidx    <= w_head.vidx;
        r_cnt     <= 2'd1;
      end else if (w_take) begin
        r_regwen  <= w_head.regw;
        r_wbidx   <= w_head.idx;
        r_wbdata  <= w_head.data;
        r_ccwen   <= w_head.ccw;
        r_cc      <= w_cc;
        r_pcen    <= w_head.pcw;
        r_pc      <= w_head.pc;
        r_cnt     <= 2'd0;
`ifdef WB_RETIRE_CNT_EN
        r_retire  <= r_retire + 32'd1;
`endif
      end else begin
        r_cnt     <= 2'd0;
      end
    end
  end

  assign O_MW_Ready         = r_ready;
  assign O_Busy             = r_busy;
  assign O_RegWEn           = r_regwen;
  assign O_WriteBackRegIdx  = r_wbidx;
  assign O_WriteBackData    = r_wbdata;
  assign O_CCWEn            = r_ccwen;
  assign O_CCValue          = r_cc;
  assign O_VRegWEn          = r_vregwen;
  assign O_WriteBackVRegIdx = r_wbvidx;
  assign O_VecCompIdx       = r_vcomp;
  assign O_WriteBackPC      = r_pc;
  assign O_WriteBackPCEn    = r_pcen;
`ifdef WB_RETIRE_CNT_EN
  assign O_RetireCount      = r_retire;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
// Retire-counter checks compile in with WB_RETIRE_CNT_EN.
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready;
  logic        regw;
  logic        vregw;
  logic        ccw;
  logic [3:0]  idx;
  logic [5:0]  vidx;
  logic [15:0] data;
  logic [63:0] vec;
  logic        pcw;
  logic [15:0] tpc;
  logic        regwen;
  logic [3:0]  wbidx;
  logic [15:0] wbdata;
  logic        ccwen;
  logic [2:0]  cc;
  logic        vregwen;
  logic [5:0]  wbvidx;
  logic [1:0]  comp;
  logic [15:0] wbpc;
  logic        pcen;
  logic        busy;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] ret;
`endif

  int total = 0;
  int bad   = 0;

  writeback_unit dut (
    .I_CLOCK            (clk),
    .I_RESET            (rst),
    .I_MW_Valid         (valid),
    .O_MW_Ready         (ready),
    .I_MW_RegWrite      (regw),
    .I_MW_VRegWrite     (vregw),
    .I_MW_CCWrite       (ccw),
    .I_MW_DestRegIdx    (idx),
    .I_MW_DestVRegIdx   (vidx),
    .I_MW_Data          (data),
    .I_MW_VecData       (vec),
    .I_MW_PCWrite       (pcw),
    .I_MW_TargetPC      (tpc),
    .O_RegWEn           (regwen),
    .O_WriteBackRegIdx  (wbidx),
    .O_WriteBackData    (wbdata),
    .O_CCWEn            (ccwen),
    .O_CCValue          (cc),
    .O_VRegWEn          (vregwen),
    .O_WriteBackVRegIdx (wbvidx),
    .O_VecCompIdx       (comp),
    .O_WriteBackPC      (wbpc),
`ifdef WB_RETIRE_CNT_EN
    .O_RetireCount      (ret),
`endif
    .O_WriteBackPCEn    (pcen),
    .O_Busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid = 0; regw = 0; vregw = 0; ccw = 0; pcw = 0;
    idx = 0; vidx = 0; data = 0; vec = 0; tpc = 0;
  endtask

  task automatic drv_s(input logic rw, input logic cw, input logic pw,
                       input logic [3:0] i, input logic [15:0] d,
                       input logic [15:0] p);
    idle_in();
    valid = 1; regw = rw; ccw = cw; pcw = pw;
    idx = i; data = d; tpc = p;
  endtask

  task automatic drv_v(input logic [5:0] vi, input logic [63:0] v);
    idle_in();
    valid = 1; vregw = 1; vidx = vi; vec = v;
  endtask

  logic [63:0] vq [3];
  logic [63:0] tmp;
  int          pushed;
  int          beats;
  logic        saw_full;
  logic        acc;

  initial begin
    idle_in();
    rst = 1;
    tick();
    tick();
    chk("rst_ready", ready, 0);
    chk("rst_regwen", regwen, 0);
    chk("rst_vregwen", vregwen, 0);
    chk("rst_busy", busy, 0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retire", ret, 0);
`endif
    rst = 0;
    tick();
    chk("ready_after_rst", ready, 1);

    // scalar write with negative result
    drv_s(1, 1, 0, 4'd3, 16'hFFFE, 16'h0);
    tick();
    idle_in();
    chk("s_lat_regwen", regwen, 0);
    chk("s_lat_busy", busy, 1);
    tick();
    chk("s_regwen", regwen, 1);
    chk("s_idx", wbidx, 3);
    chk("s_data", wbdata, 16'hFFFE);
    chk("s_ccwen", ccwen, 1);
    chk("s_cc", cc, 3'b100);
    tick();
    chk("s_after_regwen", regwen, 0);
    chk("s_after_ccwen", ccwen, 0);
    chk("s_after_data", wbdata, 0);
    chk("s_after_busy", busy, 0);

    // single vector result
    drv_v(6'd5, 64'h4444_3333_2222_1111);
    tick();
    idle_in();
    tmp = 64'h4444_3333_2222_1111;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("v_vregwen", vregwen, 1);
      chk("v_comp", comp, c);
      chk("v_data", wbdata, tmp[c*16 +: 16]);
      chk("v_vidx", wbvidx, 5);
      chk("v_regwen", regwen, 0);
      chk("v_ccwen", ccwen, 0);
      chk("v_busy", busy, 1);
    end
    tick();
    chk("v_end_vregwen", vregwen, 0);
    chk("v_end_busy", busy, 0);

    // vector then CMP back to back
    drv_v(6'd2, 64'hDDDD_CCCC_BBBB_AAAA);
    tick();
    drv_s(0, 1, 0, 4'd0, 16'h0000, 16'h0);
    tick();
    idle_in();
    chk("vc_c0", wbdata, 16'hAAAA);
    tick();
    tick();
    tick();
    chk("vc_c3_comp", comp, 3);
    chk("vc_c3_data", wbdata, 16'hDDDD);
    tick();
    chk("vc_cmp_vregwen", vregwen, 0);
    chk("vc_cmp_regwen", regwen, 0);
    chk("vc_cmp_ccwen", ccwen, 1);
    chk("vc_cmp_cc", cc, 3'b010);
    tick();
    chk("vc_idle_ccwen", ccwen, 0);

    // three vectors with valid held high
    vq[0] = 64'hA003_A002_A001_A000;
    vq[1] = 64'hB003_B002_B001_B000;
    vq[2] = 64'hC003_C002_C001_C000;
    pushed = 0;
    beats = 0;
    saw_full = 0;
    drv_v(6'd7, vq[0]);
    for (int cyc = 0; cyc < 40 && beats < 12; cyc++) begin
      acc = valid && ready;
      if (!ready) saw_full = 1;
      tick();
      if (acc) begin
        pushed++;
        if (pushed < 3) drv_v(6'd7, vq[pushed]);
        else idle_in();
      end
      if (vregwen) begin
        tmp = vq[beats/4];
        chk("bp_data", wbdata, tmp[(beats%4)*16 +: 16]);
        chk("bp_comp", comp, beats % 4);
        beats++;
      end
    end
    idle_in();
    chk("bp_beats", beats, 12);
    chk("bp_pushed", pushed, 3);
    chk("bp_saw_full", saw_full, 1);
    tick();
    chk("bp_done_vregwen", vregwen, 0);

    // branch redirect
    drv_s(0, 0, 1, 4'd0, 16'h0005, 16'h0040);
    tick();
    idle_in();
    tick();
    chk("br_pcen", pcen, 1);
    chk("br_pc", wbpc, 16'h0040);
    chk("br_regwen", regwen, 0);
    tick();
    chk("br_pcen_off", pcen, 0);

    // reset during component 1 with a scalar buffered behind
    drv_v(6'd9, 64'h9999_8888_7777_6666);
    tick();
    drv_s(1, 0, 0, 4'd2, 16'h0007, 16'h0);
    tick();
    idle_in();
    tick();
    chk("rv_comp1", comp, 1);
    chk("rv_vregwen", vregwen, 1);
    rst = 1;
    tick();
    chk("rv_rst_vregwen", vregwen, 0);
    chk("rv_rst_regwen", regwen, 0);
    chk("rv_rst_busy", busy, 0);
    rst = 0;
    tick();
    chk("rv_ready", ready, 1);
    chk("rv_vregwen2", vregwen, 0);
    chk("rv_regwen2", regwen, 0);
    chk("rv_busy2", busy, 0);
    tick();
    chk("rv_regwen3", regwen, 0);
    chk("rv_vregwen3", vregwen, 0);

`ifdef WB_RETIRE_CNT_EN
    chk("rc_zero", ret, 0);
    drv_s(1, 0, 0, 4'd1, 16'h0001, 16'h0);
    tick();
    drv_s(1, 0, 0, 4'd2, 16'h0002, 16'h0);
    tick();
    chk("rc_s1", ret, 1);
    drv_v(6'd3, 64'h0004_0003_0002_0001);
    tick();
    idle_in();
    chk("rc_s2", ret, 2);
    tick();
    chk("rc_v0", ret, 2);
    tick();
    tick();
    chk("rc_v2", ret, 2);
    tick();
    chk("rc_v3", ret, 3);
    tick();
    chk("rc_hold", ret, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
